// File: rtl/secded_pipe_corrector.sv
// Two-stage pipelined SEC-DED decoder over a valid/ready stream, with saturating
// single/double error counters and a first-uncorrectable-syndrome log.
module secded_pipe_corrector #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CHK_W  = 7,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              id_clk,
   input  logic              id_rst_n,
   input  logic              id_in_valid,
   output logic              id_in_ready,
   input  logic [DATA_W-1:0] id_in_data,
   input  logic [CHK_W-1:0]  id_in_chk,
   input  logic              id_corr_en,
   output logic              id_out_valid,
   input  logic              id_out_ready,
   output logic [DATA_W-1:0] id_out_data,
   output logic              id_out_sbe,
   output logic              id_out_dbe,
   input  logic              id_cnt_clr,
   output logic [CNT_W-1:0]  id_sbe_cnt,
   output logic [CNT_W-1:0]  id_dbe_cnt,
   output logic              id_log_valid,
   output logic [CHK_W-1:0]  id_log_syn
);

   localparam int unsigned LOW_W = CHK_W - 1;
   localparam int unsigned N_POS = DATA_W + CHK_W - 1;

   // Codeword position of data bit k: k-th non-power-of-two position from 3 upward.
   function automatic int unsigned data_pos(input int unsigned k);
      int unsigned n;
      int unsigned p;
      n = 0;
      p = 0;
      for (int unsigned q = 3; q <= N_POS; q++) begin
         if ((q & (q - 1)) != 0) begin
            if (n == k) p = q;
            n++;
         end
      end
      return p;
   endfunction

   function automatic logic [DATA_W-1:0] chk_mask(input int unsigned i);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < DATA_W; k++)
         m = m | (DATA_W'((data_pos(k) >> i) & 32'd1) << k);
      return m;
   endfunction

   logic [LOW_W-1:0]  chk_calc_c;
   logic [CHK_W-1:0]  syn_in_c;

   for (genvar i = 0; i < LOW_W; i++) begin : g_chk
      localparam logic [DATA_W-1:0] MASK = chk_mask(i);
      assign chk_calc_c[i] = ^(id_in_data & MASK);
   end

   assign syn_in_c = {(^id_in_data) ^ (^id_in_chk), chk_calc_c ^ id_in_chk[LOW_W-1:0]};

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_data_q,  s1_data_d;
   logic [CHK_W-1:0]  s1_syn_q,   s1_syn_d;
   logic              s1_corr_q,  s1_corr_d;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q,  s2_data_d;
   logic              s2_sbe_q,   s2_sbe_d;
   logic              s2_dbe_q,   s2_dbe_d;
   logic [CHK_W-1:0]  s2_syn_q,   s2_syn_d;
   logic [CNT_W-1:0]  sbe_cnt_q,  sbe_cnt_d;
   logic [CNT_W-1:0]  dbe_cnt_q,  dbe_cnt_d;
   logic              log_valid_q, log_valid_d;
   logic [CHK_W-1:0]  log_syn_q,  log_syn_d;

   // Stage-2 classification of the registered syndrome.
   logic [LOW_W-1:0]  s_low_c;
   logic [DATA_W-1:0] flip_c;
   logic              pow2_c, sbe_c, dbe_c;
   logic [DATA_W-1:0] corr_data_c;

   assign s_low_c = s1_syn_q[LOW_W-1:0];

   for (genvar k = 0; k < DATA_W; k++) begin : g_pos
      localparam int unsigned POS = data_pos(k);
      assign flip_c[k] = (s_low_c == LOW_W'(POS));
   end

   assign pow2_c      = (s_low_c != '0) && ((s_low_c & (s_low_c - LOW_W'(1))) == '0);
   assign sbe_c       = s1_syn_q[CHK_W-1] & ((s_low_c == '0) | pow2_c | (|flip_c));
   assign dbe_c       = (s1_syn_q != '0) & ~sbe_c;
   assign corr_data_c = s1_data_q ^ (flip_c & {DATA_W{s1_corr_q & sbe_c}});

   logic s2_adv_c, in_fire_c, out_fire_c;

   assign s2_adv_c    = ~s2_valid_q | id_out_ready;
   assign id_in_ready = ~s1_valid_q | s2_adv_c;
   assign in_fire_c   = id_in_valid & id_in_ready;
   assign out_fire_c  = s2_valid_q & id_out_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_syn_d    = s1_syn_q;
      s1_corr_d   = s1_corr_q;
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;
      s2_sbe_d    = s2_sbe_q;
      s2_dbe_d    = s2_dbe_q;
      s2_syn_d    = s2_syn_q;
      sbe_cnt_d   = sbe_cnt_q;
      dbe_cnt_d   = dbe_cnt_q;
      log_valid_d = log_valid_q;
      log_syn_d   = log_syn_q;

      // Empty slots load zeros so flags read 0 whenever out_valid is low.
      if (s2_adv_c) begin
         s2_valid_d = s1_valid_q;
         s2_data_d  = s1_valid_q ? corr_data_c : '0;
         s2_sbe_d   = s1_valid_q & sbe_c;
         s2_dbe_d   = s1_valid_q & dbe_c;
         s2_syn_d   = s1_valid_q ? s1_syn_q : '0;
      end

      if (in_fire_c) begin
         s1_valid_d = 1'b1;
         s1_data_d  = id_in_data;
         s1_syn_d   = syn_in_c;
         s1_corr_d  = id_corr_en;
      end else if (s2_adv_c) begin
         s1_valid_d = 1'b0;
      end

      if (id_cnt_clr) begin
         sbe_cnt_d   = '0;
         dbe_cnt_d   = '0;
         log_valid_d = 1'b0;
         log_syn_d   = '0;
      end else if (out_fire_c) begin
         if (s2_sbe_q && sbe_cnt_q != '1) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
         if (s2_dbe_q && dbe_cnt_q != '1) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
         if (s2_dbe_q && !log_valid_q) begin
            log_valid_d = 1'b1;
            log_syn_d   = s2_syn_q;
         end
      end
   end

   always_ff @(posedge id_clk) begin
      if (!id_rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_syn_q    <= '0;
         s1_corr_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
         s2_sbe_q    <= 1'b0;
         s2_dbe_q    <= 1'b0;
         s2_syn_q    <= '0;
         sbe_cnt_q   <= '0;
         dbe_cnt_q   <= '0;
         log_valid_q <= 1'b0;
         log_syn_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_syn_q    <= s1_syn_d;
         s1_corr_q   <= s1_corr_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
         s2_sbe_q    <= s2_sbe_d;
         s2_dbe_q    <= s2_dbe_d;
         s2_syn_q    <= s2_syn_d;
         sbe_cnt_q   <= sbe_cnt_d;
         dbe_cnt_q   <= dbe_cnt_d;
         log_valid_q <= log_valid_d;
         log_syn_q   <= log_syn_d;
      end
   end

   assign id_out_valid = s2_valid_q;
   assign id_out_data  = s2_data_q;
   assign id_out_sbe   = s2_sbe_q;
   assign id_out_dbe   = s2_dbe_q;
   assign id_sbe_cnt   = sbe_cnt_q;
   assign id_dbe_cnt   = dbe_cnt_q;
   assign id_log_valid = log_valid_q;
   assign id_log_syn   = log_syn_q;

endmodule

// File: tb/tb_secded_pipe_corrector.sv
// Bench for secded_pipe_corrector: codeword-level reference decoder plus scoreboard,
// and directed vectors with literal expected results.
module tb_secded_pipe_corrector;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 7;
   localparam int unsigned NW = 4;
   localparam int          NPOS = 38;
   localparam int          CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, corr_en;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_chk;
   logic          out_valid, out_ready, out_sbe, out_dbe;
   logic [DW-1:0] out_data;
   logic          cnt_clr;
   logic [NW-1:0] sbe_cnt, dbe_cnt;
   logic          log_valid;
   logic [CW-1:0] log_syn;

   secded_pipe_corrector #(.DATA_W(DW), .CHK_W(CW), .CNT_W(NW)) dut (
      .id_clk(clk), .id_rst_n(rst_n),
      .id_in_valid(in_valid), .id_in_ready(in_ready),
      .id_in_data(in_data), .id_in_chk(in_chk), .id_corr_en(corr_en),
      .id_out_valid(out_valid), .id_out_ready(out_ready),
      .id_out_data(out_data), .id_out_sbe(out_sbe), .id_out_dbe(out_dbe),
      .id_cnt_clr(cnt_clr), .id_sbe_cnt(sbe_cnt), .id_dbe_cnt(dbe_cnt),
      .id_log_valid(log_valid), .id_log_syn(log_syn)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sbe;
      logic          dbe;
      logic [CW-1:0] syn;
   } exp_t;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic bit is_pow2(input int x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   // Reference: lay out the full codeword, syndrome = XOR of indices of set bits.
   function automatic exp_t model(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ce);
      logic cw [0:NPOS];
      int   k, ci, s;
      logic p;
      exp_t r;
      k = 0; ci = 0;
      cw[0] = 1'b0;
      for (int pos = 1; pos <= NPOS; pos++) begin
         if (is_pow2(pos)) begin cw[pos] = c[ci]; ci++; end
         else begin cw[pos] = d[k]; k++; end
      end
      s = 0; p = c[CW-1];
      for (int pos = 1; pos <= NPOS; pos++)
         if (cw[pos]) begin s = s ^ pos; p = ~p; end
      r.syn = {p, 6'(s)}; r.data = d; r.sbe = 1'b0; r.dbe = 1'b0;
      if (s == 0 && !p) begin
      end else if (p && s <= NPOS) begin
         r.sbe = 1'b1;
         if (ce && s != 0 && !is_pow2(s)) begin
            cw[s] = ~cw[s];
            k = 0;
            for (int pos = 1; pos <= NPOS; pos++)
               if (!is_pow2(pos)) begin r.data[k] = cw[pos]; k++; end
         end
      end else begin
         r.dbe = 1'b1;
      end
      return r;
   endfunction

   exp_t q[$];
   int   m_sbe = 0, m_dbe = 0;
   logic m_logv = 1'b0;
   logic [CW-1:0] m_syn = '0;

   // Compare process: values at the falling edge are those the next rising edge sees.
   initial forever begin
      exp_t e;
      logic ev_s, ev_d;
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         m_sbe = 0; m_dbe = 0; m_logv = 1'b0; m_syn = '0;
      end else begin
         check("sbe_cnt", 64'(sbe_cnt), 64'(m_sbe));
         check("dbe_cnt", 64'(dbe_cnt), 64'(m_dbe));
         check("log_valid", 64'(log_valid), 64'(m_logv));
         check("log_syn", 64'(log_syn), 64'(m_syn));
         ev_s = 1'b0; ev_d = 1'b0;
         e = '0;
         if (out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
               e = q[0];
               check("out_data", 64'(out_data), 64'(e.data));
               check("out_sbe", 64'(out_sbe), 64'(e.sbe));
               check("out_dbe", 64'(out_dbe), 64'(e.dbe));
               if (out_ready) begin
                  void'(q.pop_front());
                  ev_s = e.sbe; ev_d = e.dbe;
               end
            end
         end else begin
            check("idle_flags", 64'({out_sbe, out_dbe}), 64'(0));
         end
         if (in_valid && in_ready) q.push_back(model(in_data, in_chk, corr_en));
         if (cnt_clr) begin
            m_sbe = 0; m_dbe = 0; m_logv = 1'b0; m_syn = '0;
         end else begin
            if (ev_s && m_sbe < CMAX) m_sbe++;
            if (ev_d && m_dbe < CMAX) m_dbe++;
            if (ev_d && !m_logv) begin m_logv = 1'b1; m_syn = e.syn; end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   // One word through an empty pipe with literal expectations and latency check.
   task automatic single(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic ce,
                         input logic [DW-1:0] ed, input logic es, input logic edb, input string nm);
      exp_t m;
      m = model(d, c, ce);
      check({nm, "_model"}, 64'({m.data, m.sbe, m.dbe}), 64'({ed, es, edb}));
      in_valid = 1'b1; in_data = d; in_chk = c; corr_en = ce; out_ready = 1'b1;
      #1 check({nm, "_in_ready"}, 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      check({nm, "_lat1"}, 64'(out_valid), 64'(0));
      step();
      check({nm, "_valid"}, 64'(out_valid), 64'(1));
      check({nm, "_data"}, 64'(out_data), 64'(ed));
      check({nm, "_flags"}, 64'({out_sbe, out_dbe}), 64'({es, edb}));
      step();
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (q.size() != 0 && n < 30) begin step(); n++; end
      check({nm, "_drain"}, 64'(q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] wd [4];
      logic [CW-1:0] wc [4];
      int   acc, cyc;
      logic hs;
      wd[0] = 32'h1;        wc[0] = 7'h00;
      wd[1] = 32'h3;        wc[1] = 7'h00;
      wd[2] = 32'h12345678; wc[2] = 7'h00;
      wd[3] = 32'h7;        wc[3] = 7'h47;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chk = '0; corr_en = 1'b1;
      out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_data", 64'(out_data), 64'(0));
      check("rst_flags", 64'({out_sbe, out_dbe}), 64'(0));
      check("rst_cnts", 64'({sbe_cnt, dbe_cnt}), 64'(0));
      check("rst_log", 64'({log_valid, log_syn}), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));

      single(32'h0, 7'h00, 1'b1, 32'h0, 1'b0, 1'b0, "clean0");
      single(32'h1, 7'h00, 1'b1, 32'h0, 1'b1, 1'b0, "d0_fix");
      single(32'h1, 7'h00, 1'b0, 32'h1, 1'b1, 1'b0, "d0_detect");
      check("sbe_cnt_two", 64'(sbe_cnt), 64'(2));
      single(32'hF, 7'h47, 1'b1, 32'hF, 1'b0, 1'b0, "enc_clean");
      single(32'h7, 7'h47, 1'b1, 32'hF, 1'b1, 1'b0, "d3_fix");
      single(32'h8000_0000, 7'h00, 1'b1, 32'h0, 1'b1, 1'b0, "d31_fix");
      single(32'h0, 7'h01, 1'b1, 32'h0, 1'b1, 1'b0, "chk0_err");
      single(32'h0, 7'h40, 1'b1, 32'h0, 1'b1, 1'b0, "par_err");
      single(32'h0, 7'h20, 1'b1, 32'h0, 1'b1, 1'b0, "chk5_err");
      single(32'h3, 7'h00, 1'b1, 32'h3, 1'b0, 1'b1, "dbe_first");
      check("log_first", 64'({log_valid, log_syn}), 64'({1'b1, 7'h06}));
      single(32'h5, 7'h00, 1'b1, 32'h5, 1'b0, 1'b1, "dbe_second");
      check("log_kept", 64'({log_valid, log_syn}), 64'({1'b1, 7'h06}));
      single(32'h0, 7'h67, 1'b1, 32'h0, 1'b0, 1'b1, "syn_oob");
      check("dbe_cnt_three", 64'(dbe_cnt), 64'(3));

      // Backpressure: 4 words while out_ready is held low for 5 cycles.
      acc = 0; cyc = 0;
      while (acc < 4 && cyc < 40) begin
         out_ready = (cyc >= 5);
         in_valid  = 1'b1; in_data = wd[acc]; in_chk = wc[acc]; corr_en = 1'b1;
         #1;
         if (cyc == 4) begin
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_accepted", 64'(acc), 64'(2));
            check("stall_hold_data", 64'(out_data), 64'(0));
         end
         hs = in_valid & in_ready;
         step();
         if (hs) acc++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_accepted", 64'(acc), 64'(4));
      drain("stream");

      // Saturation at 15 with a 4-bit counter.
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      check("clr_all", 64'({sbe_cnt, dbe_cnt, log_valid, log_syn}), 64'(0));
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1; in_data = 32'h1; in_chk = 7'h00; corr_en = 1'b1;
         step();
      end
      in_valid = 1'b0;
      drain("sat");
      step();
      check("sbe_sat", 64'(sbe_cnt), 64'(15));

      // Clear coinciding with an sbe increment, then with a dbe log capture.
      for (int j = 0; j < 2; j++) begin
         in_valid = 1'b1; in_data = (j == 0) ? 32'h1 : 32'h3; in_chk = 7'h00;
         step();
         in_valid = 1'b0;
         step();
         check("clr_race_valid", 64'(out_valid), 64'(1));
         cnt_clr = 1'b1;
         step();
         cnt_clr = 1'b0;
         check("clr_race_cnts", 64'({sbe_cnt, dbe_cnt}), 64'(0));
         check("clr_race_log", 64'({log_valid, log_syn}), 64'(0));
      end

      // Reset with two words in flight.
      single(32'h3, 7'h00, 1'b1, 32'h3, 1'b0, 1'b1, "pre_rst_dbe");
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'h1; in_chk = 7'h00;
      step();
      in_data = 32'h3;
      step();
      in_valid = 1'b0;
      check("inflight_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("post_rst_valid", 64'(out_valid), 64'(0));
      check("post_rst_cnts", 64'({sbe_cnt, dbe_cnt}), 64'(0));
      check("post_rst_log", 64'({log_valid, log_syn}), 64'(0));
      #1 check("post_rst_ready", 64'(in_ready), 64'(1));
      step();
      check("post_rst_empty", 64'(out_valid), 64'(0));
      single(32'h8000_0000, 7'h00, 1'b0, 32'h8000_0000, 1'b1, 1'b0, "post_rst_word");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
